// File: rtl/mpu_matrix_loader.sv
// Assembles a streamed NxN (1..5) matrix of signed bytes into the packed 5x5 format
// and hands it to a downstream MPU unit. Optional idle timeout: MPU_LOADER_TIMEOUT_EN.
module mpu_matrix_loader #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [7:0]   start_size,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [7:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [199:0] matrix,
  output logic signed [7:0]   size,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [7:0]  last_idx;
  logic [4:0]  elem_idx;
  logic [7:0]  elem_base;
  logic        size_ok;
  logic        start_ok;
  logic        start_bad;
  logic        xfer;
  logic        col_wrap;
  logic        last_elem;
  logic        timeout_hit;

`ifdef MPU_LOADER_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;
`else
  // Timeout parameters have no effect in this build; fold them into an ignored net.
  logic unused_cfg;
  assign unused_cfg = |{TIMEOUT_CYCLES, CNT_W};
`endif

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign size_ok   = (start_size >= 8'sd1) && (start_size <= 8'sd5);
  assign xfer      = (state == LOAD) && in_valid;
  assign last_idx  = 8'(size) - 8'd1;
  assign col_wrap  = ({5'd0, col} == last_idx);
  assign last_elem = xfer && col_wrap && ({5'd0, row} == last_idx);
  assign elem_idx  = 5'(col) + 5'(row) * 5'd5;
  assign elem_base = {elem_idx, 3'b000};

`ifdef MPU_LOADER_TIMEOUT_EN
  // A transfer always wins over an expiring counter, so only a stalled cycle can time out.
  assign timeout_hit = (state == LOAD) && !in_valid &&
                       (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            start_ok   = 1'b1;
            state_next = LOAD;
          end else begin
            start_bad  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (last_elem) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Matrix and size are only rewritten by an accepted start, a transfer or a timeout,
  // so they stay stable in DONE and remain readable after the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '0;
      size   <= '0;
      row    <= '0;
      col    <= '0;
      err    <= 1'b0;
    end else begin
      err <= start_bad | timeout_hit;
      if (start_ok) begin
        matrix <= '0;
        size   <= start_size;
        row    <= '0;
        col    <= '0;
      end else if (xfer) begin
        matrix[elem_base +: 8] <= in_data;
        if (col_wrap) begin
          col <= '0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end else if (timeout_hit) begin
        matrix <= '0;
        size   <= '0;
        row    <= '0;
        col    <= '0;
      end
    end
  end

`ifdef MPU_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != LOAD) || xfer || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: a transaction-level model is compared against
// the DUT on every falling edge, plus literal spot checks for each scenario.
module tb_mpu_matrix_loader;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic signed [7:0]   start_size;
  logic                in_valid;
  logic                in_ready;
  logic signed [7:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [199:0] matrix;
  logic signed [7:0]   size;
  logic                busy;
  logic                err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: mode 0 idle, 1 loading, 2 holding a complete matrix.
  int                m_mode = 0;
  int                m_n = 0;
  int                m_cnt = 0;
  logic              m_err = 1'b0;
  logic signed [7:0] m_mat[25];
  logic signed [7:0] stim[25];

  mpu_matrix_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_size (start_size),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .matrix     (matrix),
    .size       (size),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [199:0] model_packed();
    logic [199:0] p;
    p = '0;
    for (int k = 0; k < 25; k++) p[8*k +: 8] = m_mat[k];
    return p;
  endfunction

  // Model: element number k of an NxN stream lands at row k/N, column k%N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_n = 0;
      m_cnt = 0;
      m_err = 1'b0;
      for (int k = 0; k < 25; k++) m_mat[k] = '0;
    end else begin
      m_err = 1'b0;
      case (m_mode)
        0: if (start) begin
          if (start_size >= 1 && start_size <= 5) begin
            m_n = int'(start_size);
            m_cnt = 0;
            for (int k = 0; k < 25; k++) m_mat[k] = '0;
            m_mode = 1;
          end else begin
            m_err = 1'b1;
          end
        end
        1: if (in_valid) begin
          m_mat[(m_cnt / m_n) * 5 + (m_cnt % m_n)] = in_data;
          m_cnt++;
          if (m_cnt == m_n * m_n) m_mode = 2;
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [199:0] actual,
                              input logic [199:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    check_output("in_ready", 200'(in_ready), 200'(m_mode == 1));
    check_output("out_valid", 200'(out_valid), 200'(m_mode == 2));
    check_output("busy", 200'(busy), 200'(m_mode != 0));
    check_output("err", 200'(err), 200'(m_err));
    check_output("size", 200'(8'(size)), 200'(8'(m_n)));
    check_output("matrix", matrix, model_packed());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int sz);
    start = 1'b1;
    start_size = 8'(sz);
    tick();
    start = 1'b0;
    start_size = '0;
  endtask

  task automatic send_elements(input int count, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data = stim[k];
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid(input int limit);
    int guard;
    guard = 0;
    while (!out_valid && guard < limit) begin
      tick();
      guard++;
    end
    check_output("out_valid_timeout", 200'(out_valid), 200'(1));
  endtask

  task automatic out_handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [199:0] ident;
  int t0;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    start_size = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    ident = '0;
    for (int k = 0; k < 5; k++) ident[48*k +: 8] = 8'd1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_output("reset_matrix", matrix, 200'd0);
    check_output("reset_flags", 200'({in_ready, out_valid, busy, err}), 200'd0);
    tick();

    // 2x2 load with in_valid held high
    $display("[TB] 2x2 load");
    t0 = cyc;
    apply_stimulus(2);
    for (int k = 0; k < 4; k++) stim[k] = 8'(k + 1);
    send_elements(4, 1'b0);
    wait_out_valid(20);
    check_output("latency_2x2", 200'(cyc - t0), 200'd5);
    check_output("e00", 200'(matrix[7:0]), 200'd1);
    check_output("e01", 200'(matrix[15:8]), 200'd2);
    check_output("e10", 200'(matrix[47:40]), 200'd3);
    check_output("e11", 200'(matrix[55:48]), 200'd4);
    check_output("zeros_row0", 200'(matrix[39:16]), 200'd0);
    check_output("zeros_rest", 200'(matrix[199:56]), 200'd0);
    check_output("size_2x2", 200'(8'(size)), 200'd2);
    apply_stimulus(3);
    check_output("start_ignored_done", 200'({out_valid, 8'(size)}), 200'h102);
    out_handshake();
    check_output("idle_after_2x2", 200'({out_valid, busy}), 200'd0);

    // 5x5 identity with gaps, held while out_ready stays low
    $display("[TB] 5x5 identity");
    apply_stimulus(5);
    for (int k = 0; k < 25; k++) stim[k] = (k % 6 == 0) ? 8'sd1 : 8'sd0;
    send_elements(25, 1'b1);
    wait_out_valid(100);
    repeat (10) tick();
    check_output("ident_held_valid", 200'(out_valid), 200'd1);
    check_output("ident_matrix", matrix, ident);
    out_handshake();
    check_output("ident_retained", matrix, ident);
    check_output("ident_idle", 200'({out_valid, busy}), 200'd0);

    // Rejected sizes
    $display("[TB] invalid sizes");
    foreach (stim[k]) stim[k] = '0;
    for (int s = 0; s < 3; s++) begin
      apply_stimulus((s == 0) ? 0 : (s == 1) ? 6 : -1);
      check_output("bad_size_err", 200'({err, in_ready, busy}), 200'b100);
      tick();
      check_output("bad_size_err_drop", 200'(err), 200'd0);
      check_output("bad_size_matrix", matrix, ident);
      check_output("bad_size_size", 200'(8'(size)), 200'd5);
    end

    // Reset partway through a 3x3 load
    $display("[TB] reset mid-load");
    apply_stimulus(3);
    for (int k = 0; k < 3; k++) stim[k] = 8'(10 + k);
    send_elements(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset_matrix", matrix, 200'd0);
    check_output("midreset_flags", 200'({in_ready, out_valid, busy, err, 8'(size)}), 200'd0);
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(3);
    for (int k = 0; k < 9; k++) stim[k] = 8'(k - 4);
    send_elements(9, 1'b0);
    wait_out_valid(20);
    check_output("fresh_e00", 200'(matrix[7:0]), 200'(8'hFC));
    check_output("fresh_e22", 200'(matrix[103:96]), 200'(8'h04));
    check_output("fresh_e03", 200'(matrix[31:24]), 200'd0);
    out_handshake();

    // Back-to-back: 1x1 then 4x4 started right after the handshake
    $display("[TB] back-to-back");
    apply_stimulus(1);
    stim[0] = -8'sd7;
    send_elements(1, 1'b0);
    wait_out_valid(5);
    check_output("one_by_one", matrix, 200'h0F9);
    check_output("one_size", 200'(8'(size)), 200'd1);
    out_handshake();
    apply_stimulus(4);
    check_output("b2b_accepted", 200'(in_ready), 200'd1);
    for (int k = 0; k < 16; k++) stim[k] = 8'(k * 9 - 70);
    send_elements(16, 1'b0);
    wait_out_valid(20);
    check_output("b2b_e00", 200'(matrix[7:0]), 200'(8'hBA));
    check_output("b2b_e33", 200'(matrix[151:144]), 200'(8'h41));
    check_output("b2b_e04", 200'(matrix[39:32]), 200'd0);
    out_handshake();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
